change_dispenser: RTL and testbench

- Downstream stage of the nickel/dime vending FSM: accepts the change amount (cents) reported at end of a vend and pays it out as timed drive pulses to dime and nickel coin-hopper solenoids.
- Uses the largest coin first, falls back to nickels when the dime tube is empty, and raises a sticky fault when the remaining change cannot be paid.
- Registered Moore FSM with pulse and gap timers and a remaining-change register.

---
 rtl/change_dispenser.sv | 149 ++++++++++++++
 tb/tb_change_dispenser.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// change_dispenser
//   Pays out an owed change amount as timed solenoid pulses to a dime hopper
//   and a nickel hopper. It pays the largest coin first and falls back to
//   nickels when the dime tube is empty. When the remaining amount cannot be
//   paid, it enters a sticky FAULT state that reports the unpaid cents.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   load         one-cycle pulse: capture change_in and start a payout
//   change_in    change owed in cents (valid with load)
//   dime_empty   dime tube empty (looked at only when choosing a coin)
//   nickel_empty nickel tube empty (looked at only when choosing a coin)
//   fault_clr    one-cycle pulse: leave FAULT and return to IDLE
//   dime_out     dime solenoid drive
//   nickel_out   nickel solenoid drive
//   busy         high in every state except IDLE
//   done         one-cycle pulse when a payout completes
//   fault        high while in FAULT
//   owed         unpaid cents while fault is high, otherwise 0
module change_dispenser #(
    parameter int AMT_W        = 5,
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [AMT_W-1:0] change_in,
    input  logic             dime_empty,
    input  logic             nickel_empty,
    input  logic             fault_clr,
    output logic             dime_out,
    output logic             nickel_out,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [AMT_W-1:0] owed
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_PULSE,
        S_GAP,
        S_FINISH,
        S_FAULT
    } state_t;

    // The timer counts 0..N-1 in PULSE and GAP, so it has to reach the larger
    // of the two terminal values.
    localparam int MAXC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [TW-1:0]    PULSE_LAST = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0]    GAP_LAST   = TW'(GAP_CYCLES - 1);
    localparam logic [AMT_W-1:0] FIVE       = AMT_W'(5);
    localparam logic [AMT_W-1:0] TEN        = AMT_W'(10);

    state_t           state;
    logic [AMT_W-1:0] remaining;
    logic [AMT_W-1:0] owed_r;
    logic [TW-1:0]    timer;
    logic             coin_dime;

    // Only whole multiples of a nickel can ever be paid out.
    function automatic logic is_mult5(input logic [AMT_W-1:0] v);
        return (v % FIVE) == '0;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            remaining <= '0;
            owed_r    <= '0;
            timer     <= '0;
            coin_dime <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load) begin
                        if (is_mult5(change_in)) begin
                            remaining <= change_in;
                            state     <= S_SELECT;
                        end else begin
                            owed_r <= change_in;
                            state  <= S_FAULT;
                        end
                    end
                end
                S_SELECT: begin
                    timer <= '0;
                    if (remaining == '0) begin
                        state <= S_FINISH;
                    end else if (remaining >= TEN && !dime_empty) begin
                        coin_dime <= 1'b1;
                        state     <= S_PULSE;
                    end else if (remaining >= FIVE && !nickel_empty) begin
                        coin_dime <= 1'b0;
                        state     <= S_PULSE;
                    end else begin
                        owed_r <= remaining;
                        state  <= S_FAULT;
                    end
                end
                S_PULSE: begin
                    if (timer == PULSE_LAST) begin
                        // SELECT already guaranteed remaining covers this coin.
                        remaining <= remaining - (coin_dime ? TEN : FIVE);
                        timer     <= '0;
                        state     <= S_GAP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_GAP: begin
                    if (timer == GAP_LAST) begin
                        timer <= '0;
                        state <= S_SELECT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                end
                S_FAULT: begin
                    if (fault_clr) begin
                        owed_r    <= '0;
                        remaining <= '0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs depend only on flops, so reset clears them immediately.
    assign dime_out   = (state == S_PULSE) && coin_dime;
    assign nickel_out = (state == S_PULSE) && !coin_dime;
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_FINISH);
    assign fault      = (state == S_FAULT);
    assign owed       = owed_r;

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser
//   Table-driven bench for change_dispenser. Each vector starts a payout in
//   cycle 0 and records every output over cycles 0..31 as bit masks, which are
//   compared with hand-derived masks. Reset behaviour has its own sequences.
module tb_change_dispenser;

    localparam int AMT_W = 5;
    localparam int NCYC  = 32;
    localparam int NVEC  = 10;

    logic             clk;
    logic             reset;
    logic             load;
    logic [AMT_W-1:0] change_in;
    logic             dime_empty;
    logic             nickel_empty;
    logic             fault_clr;
    logic             dime_out;
    logic             nickel_out;
    logic             busy;
    logic             done;
    logic             fault;
    logic [AMT_W-1:0] owed;

    int checks = 0;
    int errors = 0;

    change_dispenser #(
        .AMT_W       (AMT_W),
        .PULSE_CYCLES(4),
        .GAP_CYCLES  (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .change_in   (change_in),
        .dime_empty  (dime_empty),
        .nickel_empty(nickel_empty),
        .fault_clr   (fault_clr),
        .dime_out    (dime_out),
        .nickel_out  (nickel_out),
        .busy        (busy),
        .done        (done),
        .fault       (fault),
        .owed        (owed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // late:   dime_empty rises in cycle 3 (during the first PULSE)
    // reload: a second load of 10 is offered in cycle 5 and must be ignored
    typedef struct {
        logic [AMT_W-1:0] amt;
        logic             de;
        logic             ne;
        logic             late;
        logic             reload;
        logic [31:0]      dm;
        logic [31:0]      nm;
        logic [31:0]      bm;
        logic [31:0]      dnm;
        logic [31:0]      fm;
        logic [AMT_W-1:0] ow;
    } vec_t;

    vec_t  vecs  [NVEC];
    string names [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Entered just after a rising edge; that cycle is cycle 0.
    task automatic run_vec(input vec_t v, input string name);
        logic [31:0]      sd, sn, sb, sdn, sf;
        logic [AMT_W-1:0] sow;
        sd = '0; sn = '0; sb = '0; sdn = '0; sf = '0; sow = '0;
        dime_empty   = v.de;
        nickel_empty = v.ne;
        change_in    = v.amt;
        load         = 1'b1;
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            sd[c]  = dime_out;
            sn[c]  = nickel_out;
            sb[c]  = busy;
            sdn[c] = done;
            sf[c]  = fault;
            if (c == NCYC - 1) sow = owed;
            @(posedge clk);
            #1;
            load = 1'b0;
            if (v.reload && c + 1 == 5) begin
                load      = 1'b1;
                change_in = AMT_W'(10);
            end
            if (v.late && c + 1 == 3) dime_empty = 1'b1;
        end
        check({name, " dime_out"},   sd,  v.dm);
        check({name, " nickel_out"}, sn,  v.nm);
        check({name, " busy"},       sb,  v.bm);
        check({name, " done"},       sdn, v.dnm);
        check({name, " fault"},      sf,  v.fm);
        check({name, " owed"},       32'(sow), 32'(v.ow));
        if (v.fm[NCYC-1]) begin
            fault_clr = 1'b1;
            @(posedge clk);
            #1;
            fault_clr = 1'b0;
            @(negedge clk);
            check({name, " clr fault"}, 32'(fault), 32'd0);
            check({name, " clr owed"},  32'(owed),  32'd0);
            check({name, " clr busy"},  32'(busy),  32'd0);
            @(posedge clk);
            #1;
        end
        dime_empty   = 1'b0;
        nickel_empty = 1'b0;
    endtask

    initial begin
        //           amt     de    ne    late  reld  dime_out      nickel_out    busy          done          fault         owed
        vecs[0] = '{5'd15, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000003C, 32'h00007800, 32'h001FFFFE, 32'h00100000, 32'h00000000, 5'd0};
        vecs[1] = '{5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 32'h00000006, 32'h00000004, 32'h00000000, 5'd0};
        vecs[2] = '{5'd10, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00000000, 32'h0000783C, 32'h001FFFFE, 32'h00100000, 32'h00000000, 5'd0};
        vecs[3] = '{5'd15, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000003C, 32'h00000000, 32'hFFFFFFFE, 32'h00000000, 32'hFFFFF800, 5'd5};
        vecs[4] = '{5'd7,  1'b0, 1'b0, 1'b0, 1'b1, 32'h00000000, 32'h00000000, 32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFE, 5'd7};
        vecs[5] = '{5'd20, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000783C, 32'h00000000, 32'h001FFFFE, 32'h00100000, 32'h00000000, 5'd0};
        vecs[6] = '{5'd5,  1'b0, 1'b1, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFC, 5'd5};
        vecs[7] = '{5'd30, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00F0783C, 32'h00000000, 32'h3FFFFFFE, 32'h20000000, 32'h00000000, 5'd0};
        vecs[8] = '{5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFE, 5'd31};
        vecs[9] = '{5'd20, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000003C, 32'h00F07800, 32'h3FFFFFFE, 32'h20000000, 32'h00000000, 5'd0};
        names[0] = "pay15";
        names[1] = "pay0";
        names[2] = "pay10_no_dime";
        names[3] = "pay15_no_nickel";
        names[4] = "odd7";
        names[5] = "pay20";
        names[6] = "pay5_no_nickel";
        names[7] = "pay30";
        names[8] = "odd31";
        names[9] = "pay20_dime_runs_out";

        reset        = 1'b1;
        load         = 1'b0;
        change_in    = '0;
        dime_empty   = 1'b0;
        nickel_empty = 1'b0;
        fault_clr    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset outputs", {26'd0, dime_out, nickel_out, busy, done, fault, 1'b0},  32'd0);
        check("reset owed",    32'(owed), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], names[i]);
        end

        // Reset in the middle of a dime pulse must drop the drive at once.
        change_in = AMT_W'(15);
        load      = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("pre-reset dime_out", 32'(dime_out), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async reset drives", {27'd0, dime_out, nickel_out, busy, done, fault}, 32'd0);
        check("async reset owed",   32'(owed), 32'd0);
        @(posedge clk);
        #1;
        check("held reset drives", {27'd0, dime_out, nickel_out, busy, done, fault}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        run_vec('{5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 32'h0000003C,
                  32'h00000FFE, 32'h00000800, 32'h00000000, 5'd0}, "after_reset_pay5");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
